// File: rtl/exec_stage.sv
// Execute stage of the 16-bit core: 64-entry register file, operand forwarding
// from the instruction in EX, ALU hand-off, load-immediate and halt handling.
module exec_stage #(
    parameter int NREGS = 64,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [4:0]       alu_op,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_result,
    output logic             wb_valid,
    output logic [5:0]       wb_dest,
    output logic [WIDTH-1:0] wb_data,
    output logic             halted
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [3:0] OP_LI   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t state, stateNext;

    logic [WIDTH-1:0]        regFile [NREGS];
    logic                    exVld_p1;
    logic [3:0]              exOp_p1;
    logic [5:0]              exDest_p1;
    logic signed [WIDTH-1:0] exImm_p1;

    logic                    accept;
    logic                    exWrites;
    logic [WIDTH-1:0]        exWrData;
    logic [WIDTH-1:0]        fwdDest;
    logic [WIDTH-1:0]        fwdSrc;

    function automatic logic signed [WIDTH-1:0] signExtendImm(input logic [5:0] imm);
        return {{(WIDTH-6){imm[5]}}, imm};
    endfunction

    assign instr_ready = (state == RUN);
    assign halted      = (state == HALTED);
    assign accept      = instr_valid && instr_ready;

    // ALU ops and LI write back; NOP and HALT only occupy EX
    assign exWrites = exVld_p1 && (exOp_p1 <= OP_LI);
    assign exWrData = (exOp_p1 == OP_LI) ? exImm_p1 : alu_result;

    assign fwdDest = (exWrites && exDest_p1 == instr[11:6]) ? exWrData : regFile[instr[11:6]];
    assign fwdSrc  = (exWrites && exDest_p1 == instr[5:0])  ? exWrData : regFile[instr[5:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            RUN:     if (accept && instr[15:12] == OP_HALT) stateNext = DRAIN;
            DRAIN:   stateNext = HALTED;
            HALTED:  stateNext = HALTED;
            default: stateNext = RUN;
        endcase
    end

    // Stage p1: operands latched at accept, result written back one edge later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
            exVld_p1  <= 1'b0;
            exOp_p1   <= '0;
            exDest_p1 <= '0;
            exImm_p1  <= '0;
            alu_op    <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            wb_valid  <= 1'b0;
            wb_dest   <= '0;
            wb_data   <= '0;
        end else begin
            if (exWrites) begin
                regFile[exDest_p1] <= exWrData;
                wb_dest            <= exDest_p1;
                wb_data            <= exWrData;
            end
            wb_valid <= exWrites;
            exVld_p1 <= accept;
            if (accept) begin
                exOp_p1   <= instr[15:12];
                exDest_p1 <= instr[11:6];
                exImm_p1  <= signExtendImm(instr[5:0]);
                alu_op    <= {1'b0, instr[15:12]};
                alu_in1   <= fwdDest;
                alu_in2   <= fwdSrc;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: table vectors, hand sequences and random traffic
// against an architectural (one instruction at a time) register-file model.
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  alu_op;
    logic [15:0] alu_in1, alu_in2, alu_result;
    logic        wb_valid;
    logic [5:0]  wb_dest;
    logic [15:0] wb_data;
    logic        halted;

    exec_stage dut (
        .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_op(alu_op), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .alu_result(alu_result), .wb_valid(wb_valid),
        .wb_dest(wb_dest), .wb_data(wb_data), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] aluModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (op)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = a << 1;
            4'h6: r = a >> 1;
            4'h7: r = ~a;
            4'h8: r = b;
            4'h9: r = a + 16'd1;
            4'hA: r = a + b + 16'd1;
            4'hB: r = {a[7:0], b[7:0]} ^ 16'h5A5A;
            default: r = 16'h0;
        endcase
        return r;
    endfunction

    always_comb alu_result = alu_op[4] ? 16'h0 : aluModel(alu_op[3:0], alu_in1, alu_in2);

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [5:0] d, input logic [5:0] s);
        return {op, d, s};
    endfunction

    int nChecks = 0;
    int nFails  = 0;

    logic [15:0] mRegs [64];
    int          mState;
    logic        pend;
    logic [5:0]  pendDest, lastDest;
    logic [15:0] pendData, lastData;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 64; i++) mRegs[i] = 16'h0;
        mState   = 0;
        pend     = 1'b0;
        pendDest = '0;
        pendData = '0;
        lastDest = '0;
        lastData = '0;
    endtask

    // One clock: present (v, ins), then check writeback, state and EX operands
    task automatic cycle(input logic v, input logic [15:0] ins);
        logic        acc, wr;
        logic [3:0]  op;
        logic [5:0]  d, s;
        logic [15:0] val, opD, opS;
        @(negedge clk);
        instr       = ins;
        instr_valid = v;
        #1 check("instr_ready", instr_ready, mState == 0);
        acc = v && (mState == 0);
        op  = ins[15:12];
        d   = ins[11:6];
        s   = ins[5:0];
        opD = mRegs[d];
        opS = mRegs[s];
        wr  = 1'b0;
        val = 16'h0;
        if (acc) begin
            if (op <= 4'hB) begin
                val = aluModel(op, opD, opS);
                wr  = 1'b1;
            end else if (op == 4'hC) begin
                val = {{10{s[5]}}, s};
                wr  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("wb_valid", wb_valid, pend);
        if (pend) begin
            lastDest = pendDest;
            lastData = pendData;
        end
        check("wb_dest", wb_dest, lastDest);
        check("wb_data", wb_data, lastData);
        if (mState == 1) mState = 2;
        if (acc && op == 4'hF) mState = 1;
        check("halted", halted, mState == 2);
        if (acc) begin
            check("alu_op", alu_op, {1'b0, op});
            check("alu_in1", alu_in1, opD);
            check("alu_in2", alu_in2, opS);
        end
        pend     = wr;
        pendDest = d;
        pendData = val;
        if (wr) mRegs[d] = val;
    endtask

    typedef struct {
        logic        v;
        logic [15:0] ins;
        logic        expWbV;
        logic [15:0] expData;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int pulses;
        reset_n     = 1'b0;
        instr       = 16'h0;
        instr_valid = 1'b0;
        modelReset();

        // Reset held three cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr_ready", instr_ready, 1);
        check("rst_halted", halted, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_dest", wb_dest, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_in1", alu_in1, 0);
        check("rst_alu_in2", alu_in2, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Every register reads back zero via ADD r,r0
        for (int r = 0; r < 64; r++) cycle(1'b1, enc(4'h0, r[5:0], 6'd0));
        cycle(1'b0, 16'h0);

        // Forwarding chain and gapped OR/SHR sequence
        vecs[0]  = '{1'b1, enc(4'hC, 6'd1, 6'd5),    1'b0, 16'h0000};
        vecs[1]  = '{1'b1, enc(4'hC, 6'd2, 6'h3D),   1'b1, 16'h0005};
        vecs[2]  = '{1'b1, enc(4'h0, 6'd1, 6'd2),    1'b1, 16'hFFFD};
        vecs[3]  = '{1'b0, 16'h0,                    1'b1, 16'h0002};
        vecs[4]  = '{1'b0, 16'h0,                    1'b0, 16'h0000};
        vecs[5]  = '{1'b1, enc(4'hC, 6'd3, 6'd1),    1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 16'h0,                    1'b1, 16'h0001};
        vecs[7]  = '{1'b0, 16'h0,                    1'b0, 16'h0000};
        vecs[8]  = '{1'b1, enc(4'h3, 6'd3, 6'd3),    1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 16'h0,                    1'b1, 16'h0001};
        vecs[10] = '{1'b0, 16'h0,                    1'b0, 16'h0000};
        vecs[11] = '{1'b1, enc(4'h6, 6'd3, 6'd3),    1'b0, 16'h0000};
        vecs[12] = '{1'b0, 16'h0,                    1'b1, 16'h0000};
        vecs[13] = '{1'b0, 16'h0,                    1'b0, 16'h0000};
        vecs[14] = '{1'b0, 16'h0,                    1'b0, 16'h0000};
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].v, vecs[i].ins);
            check("tbl_wb_valid", wb_valid, vecs[i].expWbV);
            if (vecs[i].expWbV) check("tbl_wb_data", wb_data, vecs[i].expData);
            if (i >= 5 && wb_valid) pulses++;
        end
        check("or_shr_pulses", pulses, 3);

        // Opcode 0xB with forwarded operand
        cycle(1'b1, enc(4'hC, 6'd6, 6'd3));
        cycle(1'b1, enc(4'hB, 6'd6, 6'd6));
        check("opB_alu_op", alu_op, 5'h0B);
        check("opB_alu_in1", alu_in1, 16'h0003);
        check("opB_alu_in2", alu_in2, 16'h0003);
        cycle(1'b0, 16'h0);
        check("opB_wb_dest", wb_dest, 6'd6);
        check("opB_wb_data", wb_data, 16'h5959);

        // Random traffic, no HALT; small index range makes forwarding frequent
        for (int i = 0; i < 400; i++) begin
            logic        v;
            logic [3:0]  op;
            logic [5:0]  d, s;
            v  = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 3) == 0) begin
                d = 6'($urandom_range(0, 63));
                s = 6'($urandom_range(0, 63));
            end else begin
                d = 6'($urandom_range(0, 5));
                s = 6'($urandom_range(0, 5));
            end
            cycle(v, enc(op, d, s));
        end
        cycle(1'b0, 16'h0);

        // Reset while LI r5,9 sits in EX
        cycle(1'b1, enc(4'hC, 6'd5, 6'd9));
        @(negedge clk);
        instr       = enc(4'hC, 6'd5, 6'd9);
        instr_valid = 1'b1;
        reset_n     = 1'b0;
        #1 check("midrst_wb_valid", wb_valid, 0);
        repeat (2) @(posedge clk);
        #1 check("midrst_wb_valid_hold", wb_valid, 0);
        check("midrst_wb_data", wb_data, 0);
        @(negedge clk);
        instr_valid = 1'b0;
        reset_n     = 1'b1;
        modelReset();
        cycle(1'b1, enc(4'h0, 6'd5, 6'd0));
        cycle(1'b0, 16'h0);
        check("midrst_r5", wb_data, 16'h0000);
        check("midrst_r5_dest", wb_dest, 6'd5);

        // LI, NOP, HALT, then ADD presented but never accepted
        cycle(1'b1, enc(4'hC, 6'd4, 6'd7));
        cycle(1'b1, enc(4'hD, 6'd4, 6'd4));
        cycle(1'b1, enc(4'hF, 6'd0, 6'd0));
        check("halt_not_yet", halted, 0);
        for (int i = 0; i < 5; i++) cycle(1'b1, enc(4'h0, 6'd4, 6'd4));
        check("halt_halted", halted, 1);
        check("halt_ready", instr_ready, 0);
        check("halt_alu_op", alu_op, 5'h0F);
        check("halt_wb_dest", wb_dest, 6'd4);
        check("halt_wb_data", wb_data, 16'h0007);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
